// File: rtl/control_unit_risc.sv
// control_unit_risc: instruction-sequencing FSM for the RISC SPM, one micro-step per clock.
// Outputs are purely combinational from state, instruction and zero.
module control_unit_risc #(
    parameter int word_size = 8,
    parameter int op_size   = 4,
    parameter int sel1_size = 3,
    parameter int sel2_size = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 zero,
    output logic [op_size-1:0]   sel_alu,
    output logic [sel1_size-1:0] sel_bus_1_mux,
    output logic [sel2_size-1:0] sel_bus_2_mux,
    output logic [3:0]           load_R,
    output logic                 load_PC,
    output logic                 inc_PC,
    output logic                 load_IR,
    output logic                 load_Add_R,
    output logic                 load_Reg_Y,
    output logic                 load_Reg_Z,
    output logic                 write,
    output logic                 instr_done,
    output logic                 halted
);
    localparam logic [op_size-1:0] NOP = 0, ADD = 1, SUB = 2, AND = 3, NOT = 4,
                                   RD = 5, WR = 6, BR = 7, BRZ = 8;
    localparam logic [sel1_size-1:0] bus1_pc  = sel1_size'(4);
    localparam logic [sel2_size-1:0] bus2_alu = sel2_size'(0);
    localparam logic [sel2_size-1:0] bus2_mem = sel2_size'(2);

    typedef enum logic [3:0] {
        S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2,
        S_wr1, S_wr2, S_br1, S_br2, S_halt
    } state_t;

    state_t state, next_state;
    logic [op_size-1:0] opcode;
    logic [1:0] src, dest;

    assign opcode = instruction[word_size-1:word_size-op_size];
    assign src    = instruction[3:2];
    assign dest   = instruction[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_idle;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_idle: next_state = S_fet1;
            S_fet1: next_state = S_fet2;
            S_fet2: next_state = S_dec;
            S_dec:
                case (opcode)
                    NOP, NOT:      next_state = S_fet1;
                    ADD, SUB, AND: next_state = S_ex1;
                    RD:            next_state = S_rd1;
                    WR:            next_state = S_wr1;
                    BR:            next_state = S_br1;
                    BRZ:           next_state = zero ? S_br1 : S_fet1;
                    default:       next_state = S_halt;
                endcase
            S_rd1: next_state = S_rd2;
            S_wr1: next_state = S_wr2;
            S_br1: next_state = S_br2;
            S_ex1, S_rd2, S_wr2, S_br2: next_state = S_fet1;
            default: next_state = state;
        endcase
    end

    always_comb begin
        sel_alu       = NOP;
        sel_bus_1_mux = bus1_pc;
        sel_bus_2_mux = bus2_alu;
        load_R        = 4'b0000;
        load_PC       = 1'b0;
        inc_PC        = 1'b0;
        load_IR       = 1'b0;
        load_Add_R    = 1'b0;
        load_Reg_Y    = 1'b0;
        load_Reg_Z    = 1'b0;
        write         = 1'b0;
        instr_done    = 1'b0;
        halted        = 1'b0;
        case (state)
            S_fet1: load_Add_R = 1'b1;
            S_fet2: begin
                sel_bus_2_mux = bus2_mem;
                load_IR       = 1'b1;
                inc_PC        = 1'b1;
            end
            S_dec:
                case (opcode)
                    NOP: instr_done = 1'b1;
                    ADD, SUB, AND: begin
                        sel_bus_1_mux = sel1_size'(src);
                        load_Reg_Y    = 1'b1;
                    end
                    NOT: begin
                        sel_bus_1_mux = sel1_size'(src);
                        sel_alu       = NOT;
                        load_R        = 4'b0001 << dest;
                        load_Reg_Z    = 1'b1;
                        instr_done    = 1'b1;
                    end
                    RD, WR, BR: load_Add_R = 1'b1;
                    // untaken BRZ still has to step PC over its address word
                    BRZ: begin
                        load_Add_R = zero;
                        inc_PC     = !zero;
                        instr_done = !zero;
                    end
                    default: ;
                endcase
            S_ex1: begin
                sel_bus_1_mux = sel1_size'(dest);
                sel_alu       = opcode;
                load_R        = 4'b0001 << dest;
                load_Reg_Z    = 1'b1;
                instr_done    = 1'b1;
            end
            S_rd1, S_wr1: begin
                sel_bus_2_mux = bus2_mem;
                load_Add_R    = 1'b1;
                inc_PC        = 1'b1;
            end
            S_rd2: begin
                sel_bus_2_mux = bus2_mem;
                load_R        = 4'b0001 << dest;
                instr_done    = 1'b1;
            end
            S_wr2: begin
                sel_bus_1_mux = sel1_size'(src);
                write         = 1'b1;
                instr_done    = 1'b1;
            end
            S_br1: begin
                sel_bus_2_mux = bus2_mem;
                load_Add_R    = 1'b1;
            end
            S_br2: begin
                sel_bus_2_mux = bus2_mem;
                load_PC       = 1'b1;
                instr_done    = 1'b1;
            end
            S_halt: halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit_risc.sv
// tb_control_unit_risc: scoreboard bench; the driver queues the expected micro-step
// outputs of each instruction and a negedge monitor pops and compares them.
module tb_control_unit_risc;
    typedef struct packed {
        logic [3:0] alu;
        logic [2:0] s1;
        logic [1:0] s2;
        logic [3:0] lr;
        logic ld_pc, inc_pc, ld_ir, ld_ar, ld_y, ld_z, wr, done, halt;
    } out_t;

    logic clk = 0, rst = 0, zero = 0;
    logic [7:0] instruction = 0;
    logic [3:0] sel_alu, load_R;
    logic [2:0] sel_bus_1_mux;
    logic [1:0] sel_bus_2_mux;
    logic load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z, write, instr_done, halted;

    out_t q[$];
    int checks = 0, errors = 0;

    control_unit_risc dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
        .sel_alu(sel_alu), .sel_bus_1_mux(sel_bus_1_mux), .sel_bus_2_mux(sel_bus_2_mux),
        .load_R(load_R), .load_PC(load_PC), .inc_PC(inc_PC), .load_IR(load_IR),
        .load_Add_R(load_Add_R), .load_Reg_Y(load_Reg_Y), .load_Reg_Z(load_Reg_Z),
        .write(write), .instr_done(instr_done), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic out_t dflt();
        out_t o = '0;
        o.s1 = 3'd4;
        return o;
    endfunction

    always @(negedge clk) begin
        out_t act, exp;
        act = {sel_alu, sel_bus_1_mux, sel_bus_2_mux, load_R, load_PC, inc_PC, load_IR,
               load_Add_R, load_Reg_Y, load_Reg_Z, write, instr_done, halted};
        if (q.size() > 0) begin
            exp = q.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL step @%0t: got %h want %h (instr %h zero %b)", $time, act, exp, instruction, zero);
            end
        end
        checks++;
        if (!$onehot0(load_R) || (write && |load_R) || (inc_PC && load_PC)) begin
            errors++;
            $display("FAIL exclusivity @%0t: got load_R=%b write=%b inc_PC=%b load_PC=%b want exclusive", $time, load_R, write, inc_PC, load_PC);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected outputs of one instruction from S_fet1 onward, built from the ISA rules.
    task automatic expect_instr(input logic [7:0] ins, input logic z);
        out_t o;
        int op = ins[7:4];
        logic [1:0] s = ins[3:2], d = ins[1:0];
        o = dflt(); o.ld_ar = 1; q.push_back(o);
        o = dflt(); o.s2 = 2; o.ld_ir = 1; o.inc_pc = 1; q.push_back(o);
        o = dflt();
        if (op == 0) begin
            o.done = 1; q.push_back(o);
        end else if (op >= 1 && op <= 3) begin
            o.s1 = {1'b0, s}; o.ld_y = 1; q.push_back(o);
            o = dflt(); o.s1 = {1'b0, d}; o.alu = 4'(op); o.lr = 4'b1 << d; o.ld_z = 1; o.done = 1; q.push_back(o);
        end else if (op == 4) begin
            o.s1 = {1'b0, s}; o.alu = 4; o.lr = 4'b1 << d; o.ld_z = 1; o.done = 1; q.push_back(o);
        end else if ((op >= 5 && op <= 7) || (op == 8 && z)) begin
            o.ld_ar = 1; q.push_back(o);
            o = dflt(); o.s2 = 2; o.ld_ar = 1; o.inc_pc = (op == 5 || op == 6); q.push_back(o);
            o = dflt();
            o.done = 1;
            if (op == 5) begin o.s2 = 2; o.lr = 4'b1 << d; end
            else if (op == 6) begin o.s1 = {1'b0, s}; o.wr = 1; end
            else begin o.s2 = 2; o.ld_pc = 1; end
            q.push_back(o);
        end else if (op == 8) begin
            o.inc_pc = 1; o.done = 1; q.push_back(o);
        end else begin
            q.push_back(o);
        end
    endtask

    task automatic run_instr(input logic [7:0] ins, input logic z);
        instruction = ins;
        zero = z;
        expect_instr(ins, z);
        step(q.size());
    endtask

    task automatic run_halt(input logic [7:0] ins, input int n);
        out_t o = dflt();
        o.halt = 1;
        instruction = ins;
        expect_instr(ins, 1'b0);
        repeat (n) q.push_back(o);
        step(q.size());
        rst = 0;
        q.push_back(dflt());
        step(1);
        rst = 1;
        q.push_back(dflt());
        step(1);
    endtask

    initial begin
        step(1);
        repeat (2) q.push_back(dflt());
        step(2);
        rst = 1;
        q.push_back(dflt());
        step(1);
        // reset asserted partway through S_ex1 of an ADD
        instruction = 8'h1B;
        expect_instr(8'h1B, 1'b0);
        void'(q.pop_back());
        step(3);
        q.push_back(dflt());
        #2 rst = 0;
        step(1);
        q.push_back(dflt());
        step(1);
        rst = 1;
        q.push_back(dflt());
        step(1);
        run_instr(8'h1B, 1'b0);
        run_instr(8'h56, 1'b0);
        run_instr(8'h80, 1'b0);
        run_instr(8'h80, 1'b1);
        run_instr(8'h6C, 1'b1);
        run_instr(8'h27, 1'b0);
        run_instr(8'h4D, 1'b1);
        run_instr(8'h71, 1'b0);
        run_halt(8'hF0, 20);
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ins = 8'($urandom);
            if (ins[7:4] > 8 && $urandom_range(0, 9) != 0) ins[7:4] = 4'($urandom_range(0, 8));
            if (ins[7:4] > 8) run_halt(ins, $urandom_range(1, 6));
            else run_instr(ins, 1'($urandom));
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
